// File: rtl/wave_pkg.sv
// Shared constants and encodings for the wave capture stage and the display FSM
// that reads its frozen record.
package wave_pkg;

    localparam int CHANNELS    = 5;
    localparam int DEPTH       = 15;
    localparam int PRETRIG     = 3;
    localparam int SYNC_STAGES = 2;

    localparam int CHAN_W = 3;
    localparam int IDX_W  = 4;
    localparam int MODE_W = 2;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        WAIT_TRIG,
        POST,
        DONE
    } state_e;

    typedef enum logic [MODE_W-1:0] {
        TRIG_ANY  = 2'b00,
        TRIG_RISE = 2'b01,
        TRIG_FALL = 2'b10,
        TRIG_IMM  = 2'b11
    } trig_mode_e;

endpackage

// File: rtl/wave_capture_if.sv
// Control and read-port bundle between the capture stage (slave) and the
// drawing FSM (master).
interface wave_capture_if;
    import wave_pkg::*;

    logic              arm;
    logic              abort;
    logic [CHAN_W-1:0] trig_sel;
    logic [MODE_W-1:0] trig_mode;
    logic              busy;
    logic              done;
    logic [CHAN_W-1:0] rd_chan;
    logic [IDX_W-1:0]  rd_idx;
    logic              rd_bit;

    modport master (
        output arm, abort, trig_sel, trig_mode, rd_chan, rd_idx,
        input  busy, done, rd_bit
    );

    modport slave (
        input  arm, abort, trig_sel, trig_mode, rd_chan, rd_idx,
        output busy, done, rd_bit
    );

endinterface

// File: rtl/wave_capture_edge_sync.sv
// Multi-flop synchroniser over the probe bus, a one-cycle rising-edge pulse on
// bit 0 (target sample clock) and the data vector delayed by one cycle.
module edge_sync
    import wave_pkg::*;
#(
    parameter int WIDTH  = CHANNELS + 1,
    parameter int STAGES = SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic             edge_pulse,
    output logic [WIDTH-1:1] data_d
);

    logic [WIDTH-1:0] sync_q [STAGES];
    logic [WIDTH-1:0] dly_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < STAGES; s++) sync_q[s] <= '0;
            dly_q <= '0;
        end else begin
            sync_q[0] <= din;
            for (int s = 1; s < STAGES; s++) sync_q[s] <= sync_q[s-1];
            dly_q <= sync_q[STAGES-1];
        end
    end

    // Data is taken from the cycle before the pulse, i.e. the setup side of the edge.
    assign edge_pulse = sync_q[STAGES-1][0] & ~dly_q[0];
    assign data_d     = dly_q[WIDTH-1:1];

endmodule

// File: rtl/wave_capture.sv
// Pre/post-trigger logic-analyser capture: fills history, waits for a trigger
// edge, records the post-trigger samples and freezes a DEPTH-sample record.
module wave_capture
    import wave_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [CHANNELS:0] logic_in,
    wave_capture_if.slave     bus
);

    localparam logic [IDX_W-1:0]  PRE_CNT  = IDX_W'(PRETRIG);
    localparam logic [IDX_W-1:0]  POST_CNT = IDX_W'(DEPTH - PRETRIG);
    localparam logic [CHAN_W-1:0] CHAN_LIM = CHAN_W'(CHANNELS);

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    cnt_q, cnt_d;
    logic                edge_pulse;
    logic [CHANNELS:1]   data_d;
    logic [DEPTH-1:0]    sample_buf [CHANNELS];
    logic                busy, done, shift_en;
    logic [CHAN_W-1:0]   trig_ch;
    logic                trig_new, trig_old, trig_hit;
    logic [2**IDX_W-1:0] rd_word;

    edge_sync u_sync (
        .clk        (clk),
        .rst        (rst),
        .din        (logic_in),
        .edge_pulse (edge_pulse),
        .data_d     (data_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: cnt_d is read back after being assigned in the same combinational
    // pass; blocking assignment makes that read see the freshly computed value.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (bus.abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, DONE: if (bus.arm) begin
                    state_d = FILL;
                    cnt_d   = '0;
                end
                FILL: if (edge_pulse) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == PRE_CNT) state_d = WAIT_TRIG;
                end
                WAIT_TRIG: if (edge_pulse && trig_hit) begin
                    cnt_d   = IDX_W'(1);
                    state_d = (cnt_d == POST_CNT) ? DONE : POST;
                end
                POST: if (edge_pulse) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == POST_CNT) state_d = DONE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            FILL, WAIT_TRIG, POST: busy = 1'b1;
            DONE:                  done = 1'b1;
            default:               ;
        endcase
    end

    assign bus.busy = busy;
    assign bus.done = done;
    assign shift_en = edge_pulse & busy & ~bus.abort;

    // Trigger compares the incoming sample with the current newest entry.
    assign trig_ch = (bus.trig_sel < CHAN_LIM) ? bus.trig_sel : '0;

    always_comb begin
        trig_new = 1'b0;
        trig_old = 1'b0;
        trig_hit = 1'b0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (trig_ch == CHAN_W'(c)) begin
                trig_new = data_d[c+1];
                trig_old = sample_buf[c][DEPTH-1];
            end
        end
        case (trig_mode_e'(bus.trig_mode))
            TRIG_ANY:  trig_hit = trig_new ^ trig_old;
            TRIG_RISE: trig_hit = trig_new & ~trig_old;
            TRIG_FALL: trig_hit = ~trig_new & trig_old;
            TRIG_IMM:  trig_hit = 1'b1;
            default:   trig_hit = 1'b0;
        endcase
    end

    // NOTE: the sample buffer is small flop storage that must read back as all
    // zeros after reset, so it is cleared explicitly rather than left as RAM.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < CHANNELS; c++) sample_buf[c] <= '0;
        end else if (shift_en) begin
            for (int c = 0; c < CHANNELS; c++)
                sample_buf[c] <= {data_d[c+1], sample_buf[c][DEPTH-1:1]};
        end
    end

    // Zero-padded word makes out-of-range channels and indices read as 0.
    always_comb begin
        rd_word = '0;
        for (int c = 0; c < CHANNELS; c++)
            if (bus.rd_chan == CHAN_W'(c)) rd_word[DEPTH-1:0] = sample_buf[c];
    end

    always_ff @(posedge clk) begin
        if (rst) bus.rd_bit <= 1'b0;
        else     bus.rd_bit <= rd_word[bus.rd_idx];
    end

endmodule

// File: doc/wave_capture.md
Name: wave_capture

Overview:
Upstream capture stage for the waveform display FSM. It oversamples the external logic-analyser inputs in the system clock domain and detects rising edges of the target's sample clock. It fills a per-channel pre-trigger history, waits for a trigger edge on a selectable channel, then captures the post-trigger samples. It freezes the DEPTH-sample record and exposes it through a registered random-access read port to the drawing FSM.

Parameters:
CHANNELS, 5, number of data channels (logic_in[CHANNELS:1]); logic_in[0] is the target sample clock
DEPTH, 15, samples stored per channel
PRETRIG, 3, samples kept before the trigger sample; legal range 1..DEPTH-1
SYNC_STAGES, 2, synchroniser flops on every logic_in bit; minimum 2

Ports:
clk  input  1  system clock; sole clock of the block
rst  input  1  synchronous, active-high reset
logic_in  input  CHANNELS+1  asynchronous probe inputs; bit 0 is the sample clock
arm  input  1  one-cycle pulse: start a new capture
abort  input  1  one-cycle pulse: cancel the capture and return to IDLE
trig_sel  input  3  trigger channel, 0-based, indexes logic_in[trig_sel+1]; values >= CHANNELS are treated as 0
trig_mode  input  2  00 any edge, 01 rising, 10 falling, 11 immediate (first post-fill sample triggers)
busy  output  1  high in FILL, WAIT_TRIG and POST
done  output  1  high in DONE (level), record frozen
rd_chan  input  3  read channel, 0-based
rd_idx  input  4  read sample index; 0 = oldest, DEPTH-1 = newest
rd_bit  output  1  buffer[rd_chan][rd_idx], registered, 1-cycle latency; 0 when the address is out of range

Behaviour:
- Sync: every logic_in bit passes through SYNC_STAGES flops.
  - Edge detect: sclk_s is high and was low in the previous cycle, giving a 1-cycle edge pulse.
  - Captured data is the synced data from the cycle before the edge pulse (setup-side sample).
  - Supported sample clock: <= clk/4, data stable >= 3 clk around the sample edge.
- Buffer: CHANNELS x DEPTH shift registers. On a capture edge each channel shifts toward index 0 and the new sample enters at DEPTH-1.
- cnt: 4-bit sample counter.
- State machine:
  - IDLE: busy=0, done=0. arm moves to FILL with cnt=0.
  - FILL: each edge shifts and increments cnt. When cnt reaches PRETRIG after the shift, go to WAIT_TRIG.
  - WAIT_TRIG: each edge shifts. The new sample on the trigger channel is compared with the previous newest (old buffer[DEPTH-1]).
    - Trigger condition per trig_mode.
    - On trigger: cnt=1 (trigger sample counts), go to POST.
    - No trigger: stay; the history keeps rolling.
  - POST: each edge shifts and increments cnt. When cnt reaches DEPTH-PRETRIG after the shift, go to DONE.
  - Result: the trigger sample lands at index PRETRIG.
  - DONE: done=1 and the buffer holds. arm goes to FILL, cnt=0, buffer not cleared.
- arm while busy=1 is ignored.
- abort in any state goes to IDLE. The buffer is kept, but its contents are undefined for display.
- abort and arm in the same cycle: abort wins.
- An edge pulse in the same cycle as an accepted arm is not captured. Capture starts at the next edge.
- trig_sel and trig_mode are sampled every cycle. The caller holds them stable while busy.
- Reset (any cycle, including mid-capture): state=IDLE, busy=0, done=0, cnt=0, rd_bit=0, buffer all 0, synchroniser flops 0.
  - Because the synchronisers clear to 0, a logic_in[0] that is high at reset release produces a spurious edge 2 cycles later. This is accepted; only IDLE ignores it.
- Sample clock stopped: the block waits indefinitely. The only exits are abort and rst.
- The read port is usable in every state. Reads during capture return live, shifting data.

Decomposition:
- Shared package wave_pkg: CHANNELS, DEPTH, PRETRIG, the state encoding (IDLE, FILL, WAIT_TRIG, POST, DONE), and the trig_mode encodings. The display FSM reuses these.
- One sub-module: edge_sync. It is SYNC_STAGES synchronisers plus a rising-edge pulse on bit 0 and the delayed data vector, instantiated once over the full logic_in bus.

Test Plan:
- Reset mid-POST (after 8 edges), then check: busy=0, done=0, rd_bit=0 for every chan/idx, and no state change on further edges until arm.
- arm, mode=01, trig_sel=0, ch0 pattern 0,0,0,0,1,1,0,... on 20-clk-period sample edges -> done after 4 pre-fill/no-trigger edges plus 12 post edges; ch0 buffer idx0..14 = 0,0,0,1,1,0,...; idx3 = first 1.
- mode=10 on ch2 held high for 10 edges, then low -> no trigger while high (busy=1, done=0); the trigger is the first low sample at idx3, and idx0..2 = 1.
- mode=11 -> done exactly PRETRIG+DEPTH-PRETRIG = 15 edges after arm; the buffer equals the last 15 driven samples for all 5 channels (walking-ones pattern).
- arm in the same cycle as an edge pulse, plus a second arm while busy -> the coinciding edge is not in the record (done after 15 further edges in mode 11); the second arm has no effect.
- abort during WAIT_TRIG, abort+arm in the same cycle, and rd_chan=5 / rd_idx=15 -> state IDLE; arm ignored that cycle; rd_bit=0 one cycle after the out-of-range address.
